hcsr04_ranger: RTL
==================

HCSR04_RANGER -- requirements
Module: hcsr04_ranger

Interface
REQ-001 Parameter CLK_HZ, 50_000_000, system clock frequency in Hz.
REQ-002 Parameter TRIG_US, 10, trigger pulse width in µs.
REQ-003 Parameter PERIOD_MS, 60, measurement repetition period in ms, counted from trigger rising edge.
REQ-004 Parameter TIMEOUT_US, 30000, maximum wait for echo rise and maximum echo high time, in µs.
REQ-005 Parameter NEAR_CM, 10, proximity threshold in cm.
REQ-006 Parameter HYST_CM, 2, proximity release hysteresis in cm.
REQ-007 Port clk  input  1  system clock; all logic on its rising edge.
REQ-008 Port reset  input  1  asynchronous, active-high reset.
REQ-009 Port echo  input  1  asynchronous echo from the sensor.
REQ-010 Port trigger  output  1  sensor trigger pulse, registered.
REQ-011 Port distancia  output  9  last valid distance in cm, saturated at 400.
REQ-012 Port valid  output  1  one-cycle strobe when distancia/cerca/timeout update.
REQ-013 Port timeout  output  1  high when the last cycle ended by timeout; cleared by the next valid measurement.
REQ-014 Port cerca  output  1  proximity flag consumed by the measurement/process stages.

Function
REQ-015 echo SHALL pass through a 2-flop synchronizer; all echo decisions use the synchronized value; edge detection uses a third flop.
REQ-016 A 1 µs strobe SHALL be generated from clk by a modulo CLK_HZ/1_000_000 counter.
REQ-017 FSM states SHALL be IDLE, TRIG, WAIT_ECHO, MEASURE, DONE.
REQ-018 IDLE: trigger=0; when the period counter reaches PERIOD_MS*1000 µs, clear it and go to TRIG; first trigger leaves IDLE one full period after reset release.
REQ-019 TRIG: trigger=1 for exactly TRIG_US µs strobes, then WAIT_ECHO with the µs timer cleared.
REQ-020 WAIT_ECHO: on synchronized echo rising edge go to MEASURE with cm counter and 58 µs sub-counter cleared; if timer reaches TIMEOUT_US first, go to DONE flagged timeout.
REQ-021 MEASURE: cm counter SHALL increment once per completed 58 µs of echo high, saturating at 400; echo falling edge goes to DONE flagged normal; echo high for TIMEOUT_US goes to DONE flagged timeout.
REQ-022 DONE (one cycle): normal -> distancia=cm count, timeout=0; timeout -> distancia unchanged, timeout=1; valid=1 this cycle only; then IDLE.
REQ-023 cerca SHALL set when a normal result is < NEAR_CM, clear when a normal result is >= NEAR_CM+HYST_CM, clear on any timeout, otherwise hold.
REQ-024 Period counter SHALL run continuously in all states so the trigger period is PERIOD_MS regardless of echo length; if a period elapses before DONE, the next TRIG starts upon return to IDLE.
REQ-025 Echo edges in IDLE or TRIG SHALL be ignored.
REQ-026 Output latency: valid rises 3–4 clk after the echo falling edge at the pin (synchronizer + DONE).

Reset
REQ-027 reset SHALL asynchronously force state=IDLE, trigger=0, distancia=0, valid=0, timeout=0, cerca=0, all counters and synchronizer flops=0.
REQ-028 reset asserted mid-TRIG or mid-MEASURE SHALL drop trigger immediately and discard the partial measurement (no valid strobe).

Structure
REQ-029 Shared tamagotchi constants file SHALL hold CLK_HZ, NEAR_CM, HYST_CM, the 400 cm limit and the FSM state encodings.
REQ-030 The µs strobe generator SHALL be a sub-module named us_tick (ports clk, reset, tick).

Verification (CLK_HZ=50 MHz, PERIOD_MS=60)
REQ-031 Reset release, no echo -> first trigger high at 60 ms for 500 clk ±1; timeout=1, valid pulse at 30 ms after trigger fall; cerca=0.
REQ-032 Echo high 580 µs -> distancia=10, timeout=0, cerca=0, one valid pulse.
REQ-033 Echo 290 µs then 638 µs then 696 µs -> distancia 5/11/12; cerca 1/1/0.
REQ-034 Echo 290 µs (cerca=1) then no echo -> timeout=1, distancia stays 5, cerca=0.
REQ-035 Echo stuck high 30 ms -> timeout=1, distancia unchanged, no further counting; next cycle echo 1160 µs -> distancia=20, timeout=0.
REQ-036 reset pulsed 200 µs into a 580 µs echo -> all outputs 0 immediately, no valid strobe, next trigger 60 ms after release.

Source files
------------

// File: rtl/hcsr04_ranger_pkg.sv
// Shared constants for the ranger: clock default, proximity thresholds, range limit
// and FSM state encodings, plus the proximity hysteresis rule.
package hcsr04_ranger_pkg;

    localparam int CLK_HZ_DEF  = 50_000_000;
    localparam int NEAR_CM_DEF = 10;
    localparam int HYST_CM_DEF = 2;
    localparam int MAX_CM      = 400;
    localparam int US_PER_CM   = 58;
    localparam int CM_W        = 9;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_TRIG      = 3'd1;
    localparam logic [2:0] S_WAIT_ECHO = 3'd2;
    localparam logic [2:0] S_MEASURE   = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;

    // Set below near_cm, release at near_cm+hyst_cm or above, hold in the band between.
    function automatic logic next_cerca(input logic cur, input logic [CM_W-1:0] cm,
                                        input int near_cm, input int hyst_cm);
        logic res;
        res = cur;
        if (int'(cm) < near_cm) begin
            res = 1'b1;
        end else if (int'(cm) >= near_cm + hyst_cm) begin
            res = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/hcsr04_ranger_us_tick.sv
// One-cycle strobe every DIV clocks; with DIV=1 the strobe is permanently high.
module us_tick #(
    parameter int DIV = 50
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick  = (cnt_q == LAST);
    assign cnt_d = tick ? '0 : cnt_q + CW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/hcsr04_ranger.sv
// HC-SR04 ultrasonic ranger: periodic trigger, echo timing in 58 us steps,
// timeout handling and a hysteretic proximity flag.
module hcsr04_ranger
    import hcsr04_ranger_pkg::*;
#(
    parameter int CLK_HZ     = CLK_HZ_DEF,
    parameter int TRIG_US    = 10,
    parameter int PERIOD_MS  = 60,
    parameter int TIMEOUT_US = 30000,
    parameter int NEAR_CM    = NEAR_CM_DEF,
    parameter int HYST_CM    = HYST_CM_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            echo,
    output logic            trigger,
    output logic [CM_W-1:0] distancia,
    output logic            valid,
    output logic            timeout,
    output logic            cerca
);

    localparam int PERIOD_US = PERIOD_MS * 1000;
    localparam int PW = $clog2(PERIOD_US + 1);
    localparam int TW = $clog2(TIMEOUT_US + TRIG_US + 1);
    localparam logic [PW-1:0]   PERIOD_END = PW'(PERIOD_US);
    localparam logic [TW-1:0]   TRIG_LAST  = TW'(TRIG_US - 1);
    localparam logic [TW-1:0]   TO_LAST    = TW'(TIMEOUT_US - 1);
    localparam logic [5:0]      SUB_LAST   = 6'(US_PER_CM - 1);
    localparam logic [CM_W-1:0] CM_MAX     = CM_W'(MAX_CM);

    logic            tick;
    logic [2:0]      sync_q;
    logic [2:0]      state_q, state_d;
    logic            trigger_q, trigger_d;
    logic [PW-1:0]   period_q, period_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [5:0]      sub_q, sub_d;
    logic [CM_W-1:0] cm_q, cm_d;
    logic [CM_W-1:0] dist_q, dist_d;
    logic            valid_q, valid_d;
    logic            timeout_q, timeout_d;
    logic            cerca_q, cerca_d;
    logic            done_hit, done_to;
    logic            echo_rise, echo_fall;

    us_tick #(.DIV(CLK_HZ / 1_000_000)) u_us_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign echo_rise = sync_q[1] & ~sync_q[2];
    assign echo_fall = ~sync_q[1] & sync_q[2];

    always_comb begin
        state_d   = state_q;
        trigger_d = trigger_q;
        period_d  = period_q;
        timer_d   = timer_q;
        sub_d     = sub_q;
        cm_d      = cm_q;
        dist_d    = dist_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;
        cerca_d   = cerca_q;
        done_hit  = 1'b0;
        done_to   = 1'b0;

        // Saturating at the period end keeps an overdue trigger pending until IDLE.
        if (tick && period_q != PERIOD_END) begin
            period_d = period_q + PW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (period_q == PERIOD_END) begin
                    period_d  = '0;
                    timer_d   = '0;
                    trigger_d = 1'b1;
                    state_d   = S_TRIG;
                end
            end
            S_TRIG: begin
                if (tick) begin
                    if (timer_q == TRIG_LAST) begin
                        timer_d   = '0;
                        trigger_d = 1'b0;
                        state_d   = S_WAIT_ECHO;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end
            S_WAIT_ECHO: begin
                // The edge cycle already belongs to the echo pulse, so its strobe counts.
                if (echo_rise) begin
                    cm_d    = '0;
                    sub_d   = {5'b0, tick};
                    timer_d = TW'(tick);
                    state_d = S_MEASURE;
                end else if (tick) begin
                    if (timer_q == TO_LAST) begin
                        done_hit = 1'b1;
                        done_to  = 1'b1;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end
            S_MEASURE: begin
                if (echo_fall) begin
                    done_hit = 1'b1;
                end else if (tick) begin
                    if (timer_q == TO_LAST) begin
                        done_hit = 1'b1;
                        done_to  = 1'b1;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                    if (sub_q == SUB_LAST) begin
                        sub_d = '0;
                        if (cm_q != CM_MAX) begin
                            cm_d = cm_q + CM_W'(1);
                        end
                    end else begin
                        sub_d = sub_q + 6'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                trigger_d = 1'b0;
            end
        endcase

        // Results are registered on entry to DONE so valid is high exactly while in DONE.
        if (done_hit) begin
            state_d = S_DONE;
            valid_d = 1'b1;
            if (done_to) begin
                timeout_d = 1'b1;
                cerca_d   = 1'b0;
            end else begin
                dist_d    = cm_q;
                timeout_d = 1'b0;
                cerca_d   = next_cerca(cerca_q, cm_q, NEAR_CM, HYST_CM);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q    <= '0;
            state_q   <= S_IDLE;
            trigger_q <= 1'b0;
            period_q  <= '0;
            timer_q   <= '0;
            sub_q     <= '0;
            cm_q      <= '0;
            dist_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            cerca_q   <= 1'b0;
        end else begin
            sync_q    <= {sync_q[1:0], echo};
            state_q   <= state_d;
            trigger_q <= trigger_d;
            period_q  <= period_d;
            timer_q   <= timer_d;
            sub_q     <= sub_d;
            cm_q      <= cm_d;
            dist_q    <= dist_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            cerca_q   <= cerca_d;
        end
    end

    assign trigger   = trigger_q;
    assign distancia = dist_q;
    assign valid     = valid_q;
    assign timeout   = timeout_q;
    assign cerca     = cerca_q;

endmodule
